// File: rtl/btb_pkg.sv
// Shared definitions for the branch target cache.
//   - 2-bit direction counter encodings and the allocation value
//   - next_counter(): saturating counter step for a resolved branch
package btb_pkg;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    localparam logic [1:0] ALLOC_COUNTER = WEAK_T;

    // Taken moves toward STRONG_T, not-taken toward STRONG_NT; both ends stick.
    function automatic logic [1:0] next_counter(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != STRONG_T) nxt = cnt + 2'd1;
        end else begin
            if (cnt != STRONG_NT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_way_match.sv
// Combinational way selection for one set of the branch target cache.
// Ports:
//   way_tags   in  stored tags of the set, way w at [w*TAGBITWIDTH +: TAGBITWIDTH]
//   way_valid  in  valid bit per way
//   tag        in  tag being searched for
//   lru        in  LRU bit of the set (way to evict when all ways are valid)
//   hit_vec    out per-way valid && tag match
//   hit        out any way matched
//   hit_way    out index of the matching way (lowest if several)
//   victim_way out way to allocate into: lowest invalid way, else the LRU way
module btb_way_match
    import btb_pkg::*;
#(
    parameter int unsigned WAYS        = 2,
    parameter int unsigned TAGBITWIDTH = 11
) (
    input  logic [WAYS*TAGBITWIDTH-1:0] way_tags,
    input  logic [WAYS-1:0]             way_valid,
    input  logic [TAGBITWIDTH-1:0]      tag,
    input  logic                        lru,
    output logic [WAYS-1:0]             hit_vec,
    output logic                        hit,
    output logic                        hit_way,
    output logic                        victim_way
);

    always_comb begin
        hit_vec = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            hit_vec[w] = way_valid[w] && (way_tags[w*TAGBITWIDTH +: TAGBITWIDTH] == tag);
        end
    end

    assign hit = |hit_vec;

    generate
        if (WAYS == 2) begin : g_two_way
            assign hit_way    = ~hit_vec[0] & hit_vec[1];
            assign victim_way = !way_valid[0] ? 1'b0 :
                                !way_valid[1] ? 1'b1 : lru;
        end else begin : g_one_way
            assign hit_way    = 1'b0;
            assign victim_way = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/branch_target_cache.sv
// Set-associative branch target buffer with per-entry 2-bit direction
// counters and per-set LRU replacement. One lookup per cycle with a
// registered prediction one cycle later; one resolved-branch update port.
// Ports:
//   clk, async_rst (async active-high), clk_en (all state holds when low)
//   Flush                      invalidate every entry and clear LRU
//   LookupValid/LookupAddress  fetch-side lookup request
//   PredictionValid/Prediction/PredictedTaken/PredictedDestination
//                              registered lookup result
//   UpdateEnable/UpdateAddress/ActualDestination/BranchTaken
//                              execute-side writeback of a resolved branch
module branch_target_cache
    import btb_pkg::*;
#(
    parameter int unsigned DATABITWIDTH  = 16,
    parameter int unsigned SETS          = 32,
    parameter int unsigned WAYS          = 2,
    parameter int unsigned INDEXBITWIDTH = $clog2(SETS),
    parameter int unsigned TAGBITWIDTH   = DATABITWIDTH - INDEXBITWIDTH
) (
    input  logic                    clk,
    input  logic                    async_rst,
    input  logic                    clk_en,
    input  logic                    Flush,
    input  logic                    LookupValid,
    input  logic [DATABITWIDTH-1:0] LookupAddress,
    output logic                    PredictionValid,
    output logic [1:0]              Prediction,
    output logic                    PredictedTaken,
    output logic [DATABITWIDTH-1:0] PredictedDestination,
    input  logic                    UpdateEnable,
    input  logic [DATABITWIDTH-1:0] UpdateAddress,
    input  logic [DATABITWIDTH-1:0] ActualDestination,
    input  logic                    BranchTaken
);

    logic [WAYS-1:0]         valid_q [SETS];
    logic [TAGBITWIDTH-1:0]  tag_mem [SETS][WAYS];
    logic [1:0]              cnt_mem [SETS][WAYS];
    logic [DATABITWIDTH-1:0] tgt_mem [SETS][WAYS];

    logic [INDEXBITWIDTH-1:0] l_idx, u_idx;
    logic [TAGBITWIDTH-1:0]   l_tag, u_tag;
    logic [WAYS*TAGBITWIDTH-1:0] l_tags, u_tags;

    logic            l_hit, l_hit_way, l_victim_unused;
    logic [WAYS-1:0] l_hit_vec_unused;
    logic            u_hit, u_hit_way, u_victim, u_lru;
    logic [WAYS-1:0] u_hit_vec_unused;

    logic u_act, u_hit_wr, u_alloc, u_way;

    assign l_idx = LookupAddress[INDEXBITWIDTH-1:0];
    assign l_tag = LookupAddress[DATABITWIDTH-1:INDEXBITWIDTH];
    assign u_idx = UpdateAddress[INDEXBITWIDTH-1:0];
    assign u_tag = UpdateAddress[DATABITWIDTH-1:INDEXBITWIDTH];

    always_comb begin
        l_tags = '0;
        u_tags = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            l_tags[w*TAGBITWIDTH +: TAGBITWIDTH] = tag_mem[l_idx][w];
            u_tags[w*TAGBITWIDTH +: TAGBITWIDTH] = tag_mem[u_idx][w];
        end
    end

    btb_way_match #(.WAYS(WAYS), .TAGBITWIDTH(TAGBITWIDTH)) u_lookup_match (
        .way_tags   (l_tags),
        .way_valid  (valid_q[l_idx]),
        .tag        (l_tag),
        .lru        (1'b0),
        .hit_vec    (l_hit_vec_unused),
        .hit        (l_hit),
        .hit_way    (l_hit_way),
        .victim_way (l_victim_unused)
    );

    btb_way_match #(.WAYS(WAYS), .TAGBITWIDTH(TAGBITWIDTH)) u_update_match (
        .way_tags   (u_tags),
        .way_valid  (valid_q[u_idx]),
        .tag        (u_tag),
        .lru        (u_lru),
        .hit_vec    (u_hit_vec_unused),
        .hit        (u_hit),
        .hit_way    (u_hit_way),
        .victim_way (u_victim)
    );

    // Flush wins over a same-edge update, so the update is gated here.
    assign u_act    = clk_en && UpdateEnable && !Flush;
    assign u_hit_wr = u_act && u_hit;
    assign u_alloc  = u_act && !u_hit && BranchTaken;
    assign u_way    = u_hit ? u_hit_way : u_victim;

    generate
        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] lru_q;

            always_ff @(posedge clk or posedge async_rst) begin
                if (async_rst) begin
                    lru_q <= '0;
                end else if (clk_en) begin
                    if (Flush) begin
                        lru_q <= '0;
                    end else if (u_hit_wr || u_alloc) begin
                        lru_q[u_idx] <= ~u_way;
                    end
                end
            end

            assign u_lru = lru_q[u_idx];
        end else begin : g_no_lru
            assign u_lru = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (clk_en) begin
            if (Flush) begin
                for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (u_alloc) begin
                valid_q[u_idx][u_way] <= 1'b1;
            end
        end
    end

    // Tag/counter/target storage is qualified by valid_q and needs no reset.
    always_ff @(posedge clk) begin
        if (u_hit_wr) begin
            cnt_mem[u_idx][u_way] <= next_counter(cnt_mem[u_idx][u_way], BranchTaken);
            if (BranchTaken) tgt_mem[u_idx][u_way] <= ActualDestination;
        end else if (u_alloc) begin
            tag_mem[u_idx][u_way] <= u_tag;
            cnt_mem[u_idx][u_way] <= ALLOC_COUNTER;
            tgt_mem[u_idx][u_way] <= ActualDestination;
        end
    end

    // Reads see pre-update storage: same-edge lookup returns old contents.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            PredictionValid      <= 1'b0;
            Prediction           <= STRONG_NT;
            PredictedTaken       <= 1'b0;
            PredictedDestination <= '0;
        end else if (clk_en) begin
            if (LookupValid && !Flush && l_hit) begin
                PredictionValid      <= 1'b1;
                Prediction           <= cnt_mem[l_idx][l_hit_way];
                PredictedTaken       <= cnt_mem[l_idx][l_hit_way][1];
                PredictedDestination <= tgt_mem[l_idx][l_hit_way];
            end else if (LookupValid) begin
                PredictionValid      <= 1'b0;
                Prediction           <= STRONG_NT;
                PredictedTaken       <= 1'b0;
                PredictedDestination <= '0;
            end else begin
                PredictionValid <= 1'b0;
                PredictedTaken  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_cache.sv
module tb_branch_target_cache;

    logic        clk = 1'b0;
    logic        async_rst;
    logic        clk_en;
    logic        Flush;
    logic        LookupValid;
    logic [15:0] LookupAddress;
    logic        PredictionValid;
    logic [1:0]  Prediction;
    logic        PredictedTaken;
    logic [15:0] PredictedDestination;
    logic        UpdateEnable;
    logic [15:0] UpdateAddress;
    logic [15:0] ActualDestination;
    logic        BranchTaken;

    int unsigned checks = 0;
    int unsigned passed = 0;

    typedef struct {
        int          kind;   // 1: PredictionValid only, 2: all outputs
        string       name;
        logic        pv;
        logic [1:0]  pred;
        logic        pt;
        logic [15:0] dest;
    } exp_t;

    exp_t sb[$];

    branch_target_cache #(.DATABITWIDTH(16), .SETS(32), .WAYS(2)) dut (
        .clk                  (clk),
        .async_rst            (async_rst),
        .clk_en               (clk_en),
        .Flush                (Flush),
        .LookupValid          (LookupValid),
        .LookupAddress        (LookupAddress),
        .PredictionValid      (PredictionValid),
        .Prediction           (Prediction),
        .PredictedTaken       (PredictedTaken),
        .PredictedDestination (PredictedDestination),
        .UpdateEnable         (UpdateEnable),
        .UpdateAddress        (UpdateAddress),
        .ActualDestination    (ActualDestination),
        .BranchTaken          (BranchTaken)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic step(input logic lv, input logic [15:0] la,
                        input logic ue, input logic [15:0] ua, input logic [15:0] ad,
                        input logic bt, input logic fl, input logic ce,
                        input int kind, input string name,
                        input logic pv, input logic [1:0] pred, input logic [15:0] dest);
        exp_t e;
        @(negedge clk);
        LookupValid       = lv;
        LookupAddress     = la;
        UpdateEnable      = ue;
        UpdateAddress     = ua;
        ActualDestination = ad;
        BranchTaken       = bt;
        Flush             = fl;
        clk_en            = ce;
        e.kind = kind; e.name = name; e.pv = pv; e.pred = pred;
        e.pt = pv & pred[1]; e.dest = dest;
        if (kind != 0) sb.push_back(e);
        @(posedge clk);
        #1;
        if (kind != 0) begin
            e = sb.pop_front();
            chk({e.name, "_pv"}, {15'd0, PredictionValid}, {15'd0, e.pv});
            if (e.kind == 2) begin
                chk({e.name, "_pred"}, {14'd0, Prediction}, {14'd0, e.pred});
                chk({e.name, "_taken"}, {15'd0, PredictedTaken}, {15'd0, e.pt});
                chk({e.name, "_dest"}, PredictedDestination, e.dest);
            end
        end
    endtask

    task automatic lookup(input logic [15:0] a, input string name,
                          input logic pv, input logic [1:0] pred, input logic [15:0] dest);
        step(1'b1, a, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 2, name, pv, pred, dest);
    endtask

    task automatic update(input logic [15:0] a, input logic [15:0] d, input logic t, input string name);
        step(1'b0, 16'h0, 1'b1, a, d, t, 1'b0, 1'b1, 1, name, 1'b0, 2'b00, 16'h0);
    endtask

    task automatic miss(input logic [15:0] a, input string name);
        lookup(a, name, 1'b0, 2'b00, 16'h0000);
    endtask

    initial begin
        async_rst = 1'b1; clk_en = 1'b1; Flush = 1'b0;
        LookupValid = 1'b0; LookupAddress = '0;
        UpdateEnable = 1'b0; UpdateAddress = '0; ActualDestination = '0; BranchTaken = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_pv",   {15'd0, PredictionValid}, 16'h0);
        chk("reset_pred", {14'd0, Prediction}, 16'h0);
        chk("reset_dest", PredictedDestination, 16'h0);
        async_rst = 1'b0;

        // empty cache, then allocate and saturate down
        miss(16'h0040, "cold_miss");
        update(16'h0040, 16'h1234, 1'b1, "alloc_0040");
        lookup(16'h0040, "hit_alloc", 1'b1, 2'b10, 16'h1234);
        update(16'h0040, 16'hFFFF, 1'b0, "nt1");
        update(16'h0040, 16'hFFFF, 1'b0, "nt2");
        update(16'h0040, 16'hFFFF, 1'b0, "nt3");
        lookup(16'h0040, "sat_low", 1'b1, 2'b00, 16'h1234);

        // same-edge update and lookup: old contents returned
        step(1'b1, 16'h0040, 1'b1, 16'h0040, 16'h2222, 1'b1, 1'b0, 1'b1, 2,
             "rbw", 1'b1, 2'b00, 16'h1234);
        lookup(16'h0040, "after_rbw", 1'b1, 2'b01, 16'h2222);

        // conflict in set 0: third allocation evicts the LRU way holding 0x0040
        update(16'h0840, 16'hAAAA, 1'b1, "alloc_0840");
        update(16'h1040, 16'hBBBB, 1'b1, "alloc_1040");
        miss(16'h0040, "evicted_0040");
        lookup(16'h0840, "hit_0840", 1'b1, 2'b10, 16'hAAAA);
        lookup(16'h1040, "hit_1040", 1'b1, 2'b10, 16'hBBBB);

        // not-taken miss allocates nothing and disturbs nothing
        update(16'h0060, 16'hCCCC, 1'b0, "nt_miss");
        miss(16'h0060, "no_alloc_0060");
        lookup(16'h0840, "still_0840", 1'b1, 2'b10, 16'hAAAA);

        // set 1: saturate high, target overwrite only when taken
        update(16'h0041, 16'h4321, 1'b1, "alloc_0041");
        update(16'h0041, 16'h4321, 1'b1, "t1");
        update(16'h0041, 16'h4321, 1'b1, "t2");
        lookup(16'h0041, "sat_high", 1'b1, 2'b11, 16'h4321);
        update(16'h0041, 16'h5678, 1'b1, "t_newdest");
        lookup(16'h0041, "new_dest", 1'b1, 2'b11, 16'h5678);
        update(16'h0041, 16'h9999, 1'b0, "nt_keepdest");
        lookup(16'h0041, "keep_dest", 1'b1, 2'b10, 16'h5678);

        // clk_en low: outputs hold and the update is ignored
        lookup(16'h0840, "pre_hold", 1'b1, 2'b10, 16'hAAAA);
        step(1'b1, 16'h0060, 1'b1, 16'h0080, 16'h5555, 1'b1, 1'b0, 1'b0, 2,
             "hold", 1'b1, 2'b10, 16'hAAAA);
        miss(16'h0080, "no_upd_0080");
        lookup(16'h0840, "post_hold", 1'b1, 2'b10, 16'hAAAA);

        // flush beats a same-edge update; lookup on that edge reports no hit
        step(1'b1, 16'h1040, 1'b1, 16'h0080, 16'h6666, 1'b1, 1'b1, 1'b1, 1,
             "flush", 1'b0, 2'b00, 16'h0);
        miss(16'h0040, "fl_0040");
        miss(16'h0080, "fl_0080");
        miss(16'h1040, "fl_1040");
        miss(16'h0041, "fl_0041");

        // asynchronous reset between edges
        update(16'h0100, 16'h7777, 1'b1, "alloc_0100");
        lookup(16'h0100, "pre_rst", 1'b1, 2'b10, 16'h7777);
        #2;
        async_rst = 1'b1;
        #1;
        chk("async_pv",   {15'd0, PredictionValid}, 16'h0);
        chk("async_pred", {14'd0, Prediction}, 16'h0);
        chk("async_dest", PredictedDestination, 16'h0);
        #1;
        async_rst = 1'b0;
        miss(16'h0100, "rst_0100");
        miss(16'h0840, "rst_0840");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/branch_target_cache.md
Name: branch_target_cache

Overview:
Parametrised, set-associative branch target buffer with tags, per-entry 2-bit direction counters and per-set LRU replacement. Fetch issues one lookup per cycle and receives a registered prediction one cycle later. Execute writes back resolved branches through a single update port. Supports a single-cycle global flush, and every state bit that gates a hit has a defined reset.

Parameters:
DATABITWIDTH, 16, width of branch target and of lookup/update addresses
SETS, 32, number of sets; power of two, >= 2
WAYS, 2, associativity; legal values 1 or 2
INDEXBITWIDTH, $clog2(SETS), set index width (derived)
TAGBITWIDTH, DATABITWIDTH-INDEXBITWIDTH, tag width (derived)

Ports:
clk  input  1  clock
async_rst  input  1  asynchronous active-high reset
clk_en  input  1  global clock enable; all state holds when low
Flush  input  1  invalidate all entries
LookupValid  input  1  lookup request this cycle
LookupAddress  input  DATABITWIDTH  branch instruction address
PredictionValid  output  1  registered: last accepted lookup hit
Prediction  output  2  registered counter of hit entry
PredictedTaken  output  1  registered: PredictionValid && Prediction[1]
PredictedDestination  output  DATABITWIDTH  registered target of hit entry
UpdateEnable  input  1  resolved-branch writeback
UpdateAddress  input  DATABITWIDTH  address of resolved branch
ActualDestination  input  DATABITWIDTH  resolved target
BranchTaken  input  1  resolved direction

Behaviour:
- Index = addr[INDEXBITWIDTH-1:0]; tag = addr[DATABITWIDTH-1:INDEXBITWIDTH].
- Per entry: valid bit (flop), tag, 2-bit counter, target. Per set: 1 LRU bit (WAYS=2 only; names the way to evict).
- Reset (async_rst high): all valid bits = 0, LRU bits = 0, PredictionValid = 0, Prediction = 2'b00, PredictedDestination = 0. Tag, counter and target storage is not reset. Reset is asserted mid-operation at any time; the first edge after release behaves as a normal edge.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Saturating: taken increments, not-taken decrements, no wrap at 11 or 00.
- Lookup: latency 1. On an edge with clk_en && LookupValid:
  - Hit (valid && tag match in some way): outputs load that way's counter and target.
  - Miss: PredictionValid = 0; Prediction and PredictedDestination load 0.
- On an edge with clk_en && !LookupValid, PredictionValid loads 0.
- Lookups do not modify LRU.
- Update on an edge with clk_en && UpdateEnable:
  - Hit: counter takes the saturated next value. Target is overwritten only when BranchTaken. LRU is set to the other way.
  - Miss with BranchTaken: allocate. Victim is the lowest-numbered invalid way, otherwise the LRU way. Write valid = 1, tag, counter = 10, target = ActualDestination. LRU is set to the other way.
  - Miss with !BranchTaken: no state change.
- Same-edge lookup and update to the same entry: the lookup returns pre-update contents (read-before-write; no forwarding).
- Flush on an edge with clk_en: all valid bits clear and LRU bits clear. Flush has priority over a same-edge update, which is discarded. A same-edge lookup registers PredictionValid = 0.
- WAYS=1: no LRU storage; the victim is always way 0.
- clk_en low: no state change, outputs hold, inputs are ignored.

Decomposition:
- Package btb_pkg holds:
  - counter encoding constants (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T);
  - ALLOC_COUNTER = WEAK_T;
  - a function computing the saturated next counter.
- One combinational sub-module, btb_way_match: per-way tag compare producing a hit vector, the hit way index and the victim way select. It is instantiated once for the lookup port and once for the update port.

Test Plan:
- Reset then lookup 0x0040 -> next cycle PredictionValid=0, Prediction=00, PredictedDestination=0x0000.
- Update 0x0040 taken to dest 0x1234, then lookup 0x0040 -> PredictionValid=1, Prediction=10, PredictedTaken=1, dest 0x1234. Then 3 not-taken updates -> Prediction=00 (saturates), dest still 0x1234.
- Conflict case (SETS=32, WAYS=2): allocate 0x0040, then 0x0840, then 0x1040 (all set 0). Lookup 0x0040 -> miss (LRU victim). Lookups 0x0840 and 0x1040 -> hit.
- Same edge: update 0x0040 taken to 0x2222 while looking up 0x0040 with the entry previously 0x1234 -> registered dest 0x1234. A lookup one cycle later -> 0x2222.
- Flush together with a taken update to 0x0080 -> lookups to 0x0040 and 0x0080 miss. clk_en=0 during an update -> no change observed.
- async_rst pulsed between clock edges with valid entries present -> PredictionValid drops immediately. Post-release lookups all miss.
